// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor/accumulator: WIDTH-bit operands are summed
// CHUNK bits per enabled cycle, LSB chunk first, behind Start/Busy/Done.
module adder_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned N   = WIDTH / CHUNK;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW1 = CHUNK + 1;

  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_ACC = 2'd2;
  localparam logic [1:0] MODE_CLR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] part;
  logic             cy;
  logic             op1_msb;
  logic             op2_msb;

  logic [CHUNK:0]   chunk_sum_c;
  logic [WIDTH-1:0] part_shift_c;
  logic             last_c;
  logic             ovf_c;

  // Low chunk of both operands plus the running carry
  assign chunk_sum_c  = {1'b0, op1[CHUNK-1:0]} + {1'b0, op2[CHUNK-1:0]} + CW1'(cy);
  // New chunk enters at the top; after N chunks the result is fully aligned
  assign part_shift_c = (part >> CHUNK) | (WIDTH'(chunk_sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign last_c       = (cnt == CW'(N - 1));
  // Operands of equal sign producing a result of the other sign; op2 is ~B for SUB
  assign ovf_c        = (op1_msb == op2_msb) && (part_shift_c[WIDTH-1] != op1_msb);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; every transition requires En
  always_comb begin
    state_nxt = state;
    if (En) begin
      case (state)
        S_IDLE: if (Start) state_nxt = (Mode == MODE_CLR) ? S_DONE : S_CALC;
        S_CALC: if (last_c) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath, result commit and registered handshake outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      op1      <= '0;
      op2      <= '0;
      part     <= '0;
      cy       <= 1'b0;
      op1_msb  <= 1'b0;
      op2_msb  <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else if (En) begin
      Busy <= (state_nxt != S_IDLE);
      Done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (Mode == MODE_CLR) begin
              Sum      <= '0;
              Carry    <= 1'b0;
              Overflow <= 1'b0;
              Zero     <= 1'b1;
            end else begin
              op1     <= (Mode == MODE_ACC) ? Sum : A;
              op2     <= (Mode == MODE_SUB) ? ~B : B;
              op1_msb <= (Mode == MODE_ACC) ? Sum[WIDTH-1] : A[WIDTH-1];
              op2_msb <= (Mode == MODE_SUB) ? ~B[WIDTH-1] : B[WIDTH-1];
              cy      <= (Mode == MODE_SUB);
              cnt     <= '0;
              part    <= '0;
            end
          end
        end
        S_CALC: begin
          op1  <= op1 >> CHUNK;
          op2  <= op2 >> CHUNK;
          part <= part_shift_c;
          cy   <= chunk_sum_c[CHUNK];
          cnt  <= cnt + CW'(1);
          if (last_c) begin
            Sum      <= part_shift_c;
            Carry    <= chunk_sum_c[CHUNK];
            Overflow <= ovf_c;
            Zero     <= (part_shift_c == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor/accumulator; successor to the fixed 4-bit registered adder.
- Processes WIDTH-bit operands CHUNK bits per enabled cycle, LSB chunk first, behind a Start/Busy/Done handshake.
- Reports unsigned carry, signed overflow and zero flags.
- Sits in the datapath where wide arithmetic must fit a narrow per-cycle carry chain.

Parameters:
- WIDTH, 8, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits added per enabled cycle; N = WIDTH/CHUNK chunk cycles per operation (CHUNK = WIDTH gives N = 1).

Ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- En  input  1  global advance enable; when low, all state, counters and outputs hold.
- Start  input  1  request a new operation; sampled only in IDLE with En=1.
- Mode  input  2  operation, latched at Start: 0=ADD (A+B), 1=SUB (A-B), 2=ACC (Sum+B), 3=CLR.
- A  input  WIDTH  first operand, latched at Start; unused in ACC and CLR.
- B  input  WIDTH  second operand, latched at Start; unused in CLR.
- Busy  output  1  high in CALC and DONE.
- Done  output  1  high while in DONE.
- Sum  output  WIDTH  result register; also the accumulator for ACC.
- Carry  output  1  ADD/ACC: carry out of the MSB. SUB: 1 = no borrow.
- Overflow  output  1  signed two's-complement overflow of the last operation.
- Zero  output  1  1 when Sum == 0, registered with Sum.

Behaviour:
- Reset (Rst=1 at a clock edge, any state, overrides En and Start):
  - State goes to IDLE; chunk counter, latched operands and carry register clear.
  - Sum=0, Carry=0, Overflow=0, Zero=1, Busy=0, Done=0.
- FSM: IDLE -> CALC -> DONE -> IDLE. Every transition requires En=1.
- IDLE:
  - Start=1 with Mode 0/1/2: latch op1 = (ACC ? Sum : A). Latch op2 = (SUB ? ~B : B). Carry-in = (SUB ? 1 : 0). Clear chunk counter. Go to CALC.
  - Start=1 with Mode 3 (CLR): go directly to DONE. On entry, Sum=0, Carry=0, Overflow=0, Zero=1.
- CALC:
  - Each En cycle adds chunk k of op1, op2 and the carry register. Result bits go to a partial-result register; chunk carry-out goes to the carry register; k increments.
  - After chunk N-1, go to DONE and commit to outputs in the same edge: Sum = partial result, Carry = final carry-out, Overflow, Zero.
- Overflow:
  - ADD/ACC: op1 MSB == B MSB and Sum MSB != op1 MSB.
  - SUB: A MSB != B MSB and Sum MSB != A MSB.
- Arithmetic is modulo 2^WIDTH; no saturation.
- DONE: Done=1 and Busy=1; leaves to IDLE on the next En cycle.
- Latency with En held high: Start sampled at edge t gives Done high for exactly the cycle after edge t+N, i.e. N+1 edges.
- Each En=0 cycle extends the operation by one cycle. Done stays high while En=0 in DONE.
- Start in CALC or DONE is ignored; it is not queued. Back-to-back: the earliest next Start is sampled in IDLE, one cycle after DONE.
- A/B/Mode changes after Start do not affect an in-flight operation.
- Sum/Carry/Overflow/Zero change only at DONE entry or on reset; they hold otherwise, including during CALC.

Test Plan:
- (WIDTH=8, CHUNK=2) ADD A=0x7F, B=0x01, Start at edge t -> Done high after edge t+4; Sum=0x80, Carry=0, Overflow=1, Zero=0; Busy high from t to Done.
- ADD A=0xFF, B=0x01 -> Sum=0x00, Carry=1, Overflow=0, Zero=1. Then SUB A=0x00, B=0x01 -> Sum=0xFF, Carry=0 (borrow), Overflow=0. Then SUB A=0x80, B=0x01 -> Sum=0x7F, Carry=1, Overflow=1.
- CLR, then ACC B=0x10 three times -> Sum 0x10, 0x20, 0x30. CLR Done asserts on the cycle after Start and Sum=0.
- En low for 2 cycles mid-CALC, and Start pulsed while Busy -> Done delayed by exactly 2 cycles; result unchanged; no second operation runs.
- Rst high for one edge during CALC chunk 2 -> next cycle Busy=0, Done=0, Sum=0, Zero=1. A following ADD 0x12+0x34 gives Sum=0x46.
- Parameter sweep (WIDTH=16, CHUNK=16) and (WIDTH=16, CHUNK=4): 0x8000+0x8000 -> Sum=0x0000, Carry=1, Overflow=1. Latency is 1 and 4 chunk cycles respectively (Done after edges t+1 and t+4).
